// File: rtl/manchester_tx_pkg.sv
// Shared state and phase encodings for the Manchester transmit stage.
package manchester_tx_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TX   = 1'b1
  } state_t;

  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } phase_t;

endpackage

// File: rtl/manchester_tx_half_bit_timer.sv
// Loadable down-counter: ticks for one cycle at zero, then reloads from the
// value captured by the last load.
module half_bit_timer #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] load_val_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] reload_q, reload_d;

  assign tick_o = en_i && (cnt_q == '0);

  always_comb begin
    cnt_d    = cnt_q;
    reload_d = reload_q;
    if (load_i) begin
      cnt_d    = load_val_i;
      reload_d = load_val_i;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? reload_q : cnt_q - DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      reload_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
    end
  end

endmodule

// File: rtl/manchester_tx.sv
// Manchester serialiser: accepts parallel words via valid/ready and shifts
// them out MSB-first, 1 = high/low, 0 = low/high, programmable half-bit.
module manchester_tx
  import manchester_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DIV_WIDTH-1:0]  DIV_HALF,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic                  SER_OUT,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  phase_t                phase_q, phase_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  ser_q, ser_d;
  logic                  tick;
  logic                  accept;
  logic                  last_cycle;

  half_bit_timer #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_timer (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (accept),
    .en_i       (state_q == ST_TX),
    .load_val_i (DIV_HALF),
    .tick_o     (tick)
  );

  // Final cycle of bit 0's second half: also an accept slot for seamless chaining.
  assign last_cycle = (state_q == ST_TX) && (phase_q == PH_SECOND) &&
                      (idx_q == '0) && tick;
  assign IN_READY   = (state_q == ST_IDLE) || last_cycle;
  assign accept     = IN_VALID && IN_READY;
  assign DONE       = last_cycle;
  assign BUSY       = (state_q == ST_TX);
  assign SER_OUT    = ser_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    ser_d   = ser_q;
    if (accept) begin
      state_d = ST_TX;
      phase_d = PH_FIRST;
      shift_d = IN_DATA;
      idx_d   = IDX_LAST;
      ser_d   = IN_DATA[DATA_WIDTH-1];
    end else if (last_cycle) begin
      state_d = ST_IDLE;
      phase_d = PH_FIRST;
      ser_d   = 1'b0;
    end else if ((state_q == ST_TX) && tick) begin
      if (phase_q == PH_FIRST) begin
        phase_d = PH_SECOND;
        ser_d   = ~shift_q[DATA_WIDTH-1];
      end else begin
        phase_d = PH_FIRST;
        idx_d   = idx_q - IDX_W'(1);
        shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
        ser_d   = shift_q[DATA_WIDTH-2];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      phase_q <= PH_FIRST;
      shift_q <= '0;
      idx_q   <= '0;
      ser_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      ser_q   <= ser_d;
    end
  end

endmodule

// File: tb/tb_manchester_tx.sv
// Self-checking bench for manchester_tx: per-cycle comparison of
// {SER_OUT, BUSY, DONE, IN_READY} against a waveform built from the encoding rules.
module tb_manchester_tx;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] DIV_HALF;
  logic [7:0] IN_DATA;
  logic       IN_VALID;
  logic       IN_READY;
  logic       SER_OUT;
  logic       BUSY;
  logic       DONE;

  int total = 0;
  int bad   = 0;

  logic exp_ser[$];
  logic exp_done[$];

  always #5 CLK = ~CLK;

  manchester_tx #(
    .DATA_WIDTH(8),
    .DIV_WIDTH (8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .DIV_HALF (DIV_HALF),
    .IN_DATA  (IN_DATA),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .SER_OUT  (SER_OUT),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  // Expected line waveform of one word: each bit MSB-first is (d+1) cycles of
  // the bit followed by (d+1) cycles of its complement; DONE on the very last.
  function automatic void model_word(input logic [7:0] w, input int unsigned d);
    for (int b = 7; b >= 0; b--)
      for (int h = 0; h < 2; h++)
        for (int unsigned c = 0; c <= d; c++) begin
          exp_ser.push_back((h == 0) ? w[b] : ~w[b]);
          exp_done.push_back((b == 0) && (h == 1) && (c == d));
        end
  endfunction

  // Presents one word while the DUT is idle, then withdraws it.
  task automatic offer(input logic [7:0] w, input logic [7:0] d);
    IN_VALID = 1'b1;
    IN_DATA  = w;
    DIV_HALF = d;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    IN_DATA  = 8'($urandom);
  endtask

  task automatic test_reset();
    logic [3:0] ov;
    RST = 1'b1; IN_VALID = 1'b0; IN_DATA = '0; DIV_HALF = '0;
    @(posedge CLK);
    @(negedge CLK);
    ov = {SER_OUT, BUSY, DONE, IN_READY};
    total++;
    if (ov !== 4'b0001) begin bad++; $display("FAIL reset_state got=%b exp=0001", ov); end
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      ov = {SER_OUT, BUSY, DONE, IN_READY};
      total++;
      if (ov !== 4'b0001) begin bad++; $display("FAIL idle cyc=%0d got=%b exp=0001", i, ov); end
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_single(input logic [7:0] w, input logic [7:0] d);
    logic es, ed;
    logic [3:0] ov, ev;
    model_word(w, int'(d));
    offer(w, d);
    for (int i = 0; exp_ser.size() > 0; i++) begin
      @(negedge CLK);
      es = exp_ser.pop_front(); ed = exp_done.pop_front();
      ov = {SER_OUT, BUSY, DONE, IN_READY}; ev = {es, 1'b1, ed, ed};
      total++;
      if (ov !== ev) begin bad++; $display("FAIL single w=%h d=%0d cyc=%0d got=%b exp=%b", w, d, i, ov, ev); end
    end
    @(negedge CLK);
    ov = {SER_OUT, BUSY, DONE, IN_READY};
    total++;
    if (ov !== 4'b0001) begin bad++; $display("FAIL single_end w=%h got=%b exp=0001", w, ov); end
    @(posedge CLK); #1;
  endtask

  task automatic test_back_to_back();
    logic es, ed;
    logic [3:0] ov, ev;
    model_word(8'hFF, 1);
    model_word(8'h00, 1);
    IN_VALID = 1'b1; IN_DATA = 8'hFF; DIV_HALF = 8'd1;
    @(posedge CLK); #1;
    IN_DATA = 8'h00;
    for (int i = 0; exp_ser.size() > 0; i++) begin
      @(negedge CLK);
      es = exp_ser.pop_front(); ed = exp_done.pop_front();
      ov = {SER_OUT, BUSY, DONE, IN_READY}; ev = {es, 1'b1, ed, ed};
      total++;
      if (ov !== ev) begin bad++; $display("FAIL b2b cyc=%0d got=%b exp=%b", i, ov, ev); end
      if (ed) begin
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
      end
    end
    @(negedge CLK);
    ov = {SER_OUT, BUSY, DONE, IN_READY};
    total++;
    if (ov !== 4'b0001) begin bad++; $display("FAIL b2b_end got=%b exp=0001", ov); end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid();
    logic es, ed;
    logic [3:0] ov, ev;
    model_word(8'hC3, 2);
    offer(8'hC3, 8'd2);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      es = exp_ser.pop_front(); ed = exp_done.pop_front();
      ov = {SER_OUT, BUSY, DONE, IN_READY}; ev = {es, 1'b1, ed, ed};
      total++;
      if (ov !== ev) begin bad++; $display("FAIL rst_mid_pre cyc=%0d got=%b exp=%b", i, ov, ev); end
    end
    exp_ser.delete(); exp_done.delete();
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      ov = {SER_OUT, BUSY, DONE, IN_READY};
      total++;
      if (ov !== 4'b0001) begin bad++; $display("FAIL rst_mid_idle cyc=%0d got=%b exp=0001", i, ov); end
    end
    @(posedge CLK); #1;
    test_single(8'h96, 8'd0);
  endtask

  task automatic test_div_change();
    logic es, ed;
    logic [3:0] ov, ev;
    int nd;
    model_word(8'h55, 1);
    model_word(8'h3C, 5);
    offer(8'h55, 8'd1);
    DIV_HALF = 8'd1;
    nd = 0;
    for (int i = 0; exp_ser.size() > 0; i++) begin
      @(negedge CLK);
      if (i == 7) DIV_HALF = 8'd5;
      es = exp_ser.pop_front(); ed = exp_done.pop_front();
      ov = {SER_OUT, BUSY, DONE, IN_READY}; ev = {es, 1'b1, ed, ed};
      total++;
      if (ov !== ev) begin bad++; $display("FAIL divchg cyc=%0d got=%b exp=%b", i, ov, ev); end
      if (ed) begin
        nd++;
        IN_VALID = (nd == 1);
        IN_DATA  = 8'h3C;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        DIV_HALF = 8'($urandom);
      end
    end
    @(negedge CLK);
    ov = {SER_OUT, BUSY, DONE, IN_READY};
    total++;
    if (ov !== 4'b0001) begin bad++; $display("FAIL divchg_end got=%b exp=0001", ov); end
    @(posedge CLK); #1;
  endtask

  // Chained random words; between accept slots the inputs are random junk
  // (including IN_VALID) that must be ignored while IN_READY is low.
  task automatic test_random();
    logic es, ed;
    logic [3:0] ov, ev;
    logic [7:0] words[6];
    logic [7:0] divs[6];
    int k;
    for (int j = 0; j < 6; j++) begin
      words[j] = 8'($urandom);
      divs[j]  = 8'($urandom_range(0, 6));
      model_word(words[j], int'(divs[j]));
    end
    IN_VALID = 1'b1; IN_DATA = words[0]; DIV_HALF = divs[0];
    @(posedge CLK); #1;
    k = 1;
    for (int i = 0; exp_ser.size() > 0; i++) begin
      @(negedge CLK);
      es = exp_ser.pop_front(); ed = exp_done.pop_front();
      ov = {SER_OUT, BUSY, DONE, IN_READY}; ev = {es, 1'b1, ed, ed};
      total++;
      if (ov !== ev) begin bad++; $display("FAIL random cyc=%0d got=%b exp=%b", i, ov, ev); end
      if (ed) begin
        IN_VALID = (k < 6);
        if (k < 6) begin IN_DATA = words[k]; DIV_HALF = divs[k]; end
        k++;
      end else begin
        IN_VALID = 1'($urandom);
        IN_DATA  = 8'($urandom);
        DIV_HALF = 8'($urandom);
      end
    end
    IN_VALID = 1'b0;
    @(negedge CLK);
    ov = {SER_OUT, BUSY, DONE, IN_READY};
    total++;
    if (ov !== 4'b0001) begin bad++; $display("FAIL random_end got=%b exp=0001", ov); end
    @(posedge CLK); #1;
  endtask

  initial begin
    test_reset();
    test_single(8'hA5, 8'd0);
    test_single(8'h80, 8'd3);
    test_back_to_back();
    test_reset_mid();
    test_div_change();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
